// File: rtl/cpu_pkg.sv
// Shared types for the execute-stage branch resolution path: branch kinds,
// RV32I branch funct3 codes, the registered resolution record and occupancy states.
package cpu_pkg;

    localparam int unsigned CPU_XLEN = 32;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_JAL    = 2'b10,
        KIND_JALR   = 2'b11
    } br_kind_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                taken;
        logic [CPU_XLEN-1:0] target;
        logic [CPU_XLEN-1:0] link;
        logic                mispredict;
        logic                illegal;
        logic                misalign;
    } br_res_t;

    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: equality and signed/unsigned magnitude compares
// of the two operands, selected by funct3 into a taken decision.
module br_cond_eval
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = CPU_XLEN
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_funct3,
    output logic            o_taken,
    output logic            o_illegal
);

    logic w_eq;
    logic w_ltu;
    logic w_lt;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_ltu = (i_rs1 < i_rs2);
    // Differing signs decide signed order alone; otherwise the low bits order the same as unsigned.
    assign w_lt  = (i_rs1[XLEN-1] != i_rs2[XLEN-1]) ? i_rs1[XLEN-1]
                                                     : (i_rs1[XLEN-2:0] < i_rs2[XLEN-2:0]);

    // funct3 select of the resolved condition; reserved codes flag illegal and never take.
    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = w_eq;
            F3_BNE:  o_taken = !w_eq;
            F3_BLT:  o_taken = w_lt;
            F3_BGE:  o_taken = !w_lt;
            F3_BLTU: o_taken = w_ltu;
            F3_BGEU: o_taken = !w_ltu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: computes taken/target/link, checks the
// fetch prediction and returns one registered result per instruction over valid/ready.
module branch_resolve_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          XLEN     = CPU_XLEN,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      kind_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] link_o,
    output logic            mispredict_o,
    output logic            illegal_o,
    output logic            misalign_o
);

    occ_state_e      r_state;
    occ_state_e      w_state_nxt;
    br_res_t         r_res;
    br_res_t         w_res;

    logic            w_cond_taken;
    logic            w_cond_illegal;
    logic            w_accept;
    logic            w_xfer;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_taken_target;
    logic            w_taken;

    br_cond_eval #(.XLEN(XLEN)) u_cond (
        .i_rs1     (rs1_i),
        .i_rs2     (rs2_i),
        .i_funct3  (funct3_i),
        .o_taken   (w_cond_taken),
        .o_illegal (w_cond_illegal)
    );

    assign w_pc_plus4    = pc_i + {{(XLEN-3){1'b0}}, 3'd4};
    assign w_pc_rel      = pc_i + imm_i;
    assign w_jalr_sum    = rs1_i + imm_i;
    assign w_jalr_target = w_jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};

    assign out_valid_o = (r_state == OCC_FULL);
    assign in_ready_o  = !flush_i && (!out_valid_o || out_ready_i);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_xfer      = out_valid_o && out_ready_i;

    // Per-kind taken decision and taken-path target.
    always_comb begin
        w_taken        = 1'b0;
        w_taken_target = w_pc_rel;
        case (br_kind_e'(kind_i))
            KIND_BRANCH: w_taken = w_cond_taken && !w_cond_illegal;
            KIND_JAL:    w_taken = 1'b1;
            KIND_JALR: begin
                w_taken        = 1'b1;
                w_taken_target = w_jalr_target;
            end
            default:     w_taken = 1'b0;
        endcase
    end

    // Assemble the resolution record; illegal branches never request a redirect.
    always_comb begin
        w_res            = '0;
        w_res.taken      = w_taken;
        w_res.target     = w_taken ? w_taken_target : w_pc_plus4;
        w_res.link       = w_pc_plus4;
        w_res.illegal    = (br_kind_e'(kind_i) == KIND_BRANCH) && w_cond_illegal;
        w_res.misalign   = w_taken && w_res.target[1];
        if (w_res.illegal) begin
            w_res.mispredict = 1'b0;
        end else begin
            w_res.mispredict = (w_taken != pred_taken_i) ||
                               (w_taken && (w_res.target != pred_target_i));
        end
    end

    // Occupancy next-state: flush empties the slot regardless of accept or hold.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OCC_EMPTY: begin
                if (flush_i)       w_state_nxt = OCC_EMPTY;
                else if (w_accept) w_state_nxt = OCC_FULL;
                else               w_state_nxt = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (flush_i)                   w_state_nxt = OCC_EMPTY;
                else if (w_xfer && !w_accept)  w_state_nxt = OCC_EMPTY;
                else                           w_state_nxt = OCC_FULL;
            end
            default: w_state_nxt = OCC_EMPTY;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result register: loads only on accept, so a stalled result stays frozen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res            <= '0;
            r_res.target     <= RESET_PC;
            r_res.link       <= RESET_PC;
        end else if (w_accept) begin
            r_res <= w_res;
        end else begin
            r_res <= r_res;
        end
    end

    assign taken_o      = r_res.taken;
    assign target_o     = r_res.target;
    assign link_o       = r_res.link;
    assign mispredict_o = r_res.mispredict;
    assign illegal_o    = r_res.illegal;
    assign misalign_o   = r_res.misalign;

endmodule
